// File: rtl/usb_tx_pkg.sv
// Purpose: shared enums, CRC constants and line encodings for the USB transmitter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        CRC_NONE = 2'b00,
        CRC_5    = 2'b01,
        CRC_16   = 2'b10,
        CRC_ILL  = 2'b11
    } crc_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_PLD,
        ST_CRC,
        ST_EOP,
        ST_IDLE_J
    } tx_state_t;

    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Line symbols as {dp, dm}.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [2:0] STUFF_RUN = 3'd6;

    function automatic logic [1:0] nrzi_line(input logic lvl);
        return lvl ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/usb_tx_crc.sv
// Purpose: serial CRC5/CRC16 engine over payload bits; output is the complemented remainder.
// Latency: remainder updates on the edge a bit is consumed.
// Backpressure: none; bit_valid is a one-cycle strobe from the serializer.
module usb_tx_crc
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        clear,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic [1:0]  mode,
    output logic [15:0] crc_out
);

    logic [4:0]  crc5_q,  crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic        fb5, fb16;

    // Both remainders run in parallel so clear does not depend on the mode being latched yet.
    always_comb begin
        fb5     = bit_in ^ crc5_q[4];
        fb16    = bit_in ^ crc16_q[15];
        crc5_d  = crc5_q;
        crc16_d = crc16_q;
        if (clear) begin
            crc5_d  = CRC5_INIT;
            crc16_d = CRC16_INIT;
        end else if (bit_valid) begin
            crc5_d  = {crc5_q[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'd0);
            crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            crc5_q  <= CRC5_INIT;
            crc16_q <= CRC16_INIT;
        end else begin
            crc5_q  <= crc5_d;
            crc16_q <= crc16_d;
        end
    end

    assign crc_out = (mode == CRC_5) ? {11'd0, ~crc5_q} : ~crc16_q;

endmodule

// File: rtl/usb_tx_serializer.sv
// Purpose: USB packet transmitter (SYNC/PID/payload/CRC, bit stuffing, NRZI, EOP); USB_TX_STUFF_CNT_EN adds stuff_cnt.
// Latency: first SYNC bit on dp/dm the cycle after accept; one line bit per clk.
// Backpressure: ready_in low from accept until the idle cycle after the final J.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int  MAX_PLD_BITS = 64,
    parameter int  SYNC_BITS    = 8,
    parameter int  EOP_SE0      = 2,
    localparam int LEN_W        = $clog2(MAX_PLD_BITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    pkt_avail,
    output logic                    ready_in,
    input  logic [3:0]              pid,
    input  logic [MAX_PLD_BITS-1:0] payload,
    input  logic [LEN_W-1:0]        pld_bits,
    input  logic [1:0]              crc_mode,
    output logic                    dp,
    output logic                    dm,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic                    cfg_err
`ifdef USB_TX_STUFF_CNT_EN
    ,
    output logic [7:0]              stuff_cnt
`endif
);

    localparam int IDX_W = $clog2(MAX_PLD_BITS + SYNC_BITS + EOP_SE0 + 17);
    localparam int PI_W  = (MAX_PLD_BITS > 1) ? $clog2(MAX_PLD_BITS) : 1;

    tx_state_t               st_q, st_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [2:0]              ones_q, ones_d;
    logic                    lvl_q, lvl_d;
    logic [1:0]              line_q, line_d;
    logic                    rdy_q, rdy_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [3:0]              pid_q, pid_d;
    logic [MAX_PLD_BITS-1:0] pld_q, pld_d;
    logic [LEN_W-1:0]        len_q, len_d;
    crc_mode_t               mode_q, mode_d;

    logic        accept, raw, last, crc_vld;
    logic [7:0]  pid_byte;
    logic [3:0]  crc_i, crc_last;
    logic [15:0] crc_out;
    tx_state_t   nxt_pld, nxt_pid;

    assign accept   = (st_q == ST_IDLE) && rdy_q && pkt_avail;
    assign pid_byte = {~pid_q, pid_q};
    assign crc_last = (mode_q == CRC_5) ? 4'd4 : 4'd15;
    assign crc_i    = crc_last - idx_q[3:0];
    assign nxt_pld  = (mode_q == CRC_NONE) ? ST_EOP : ST_CRC;
    assign nxt_pid  = (len_q != '0) ? ST_PLD : nxt_pld;

    usb_tx_crc u_crc (
        .clk       (clk),
        .rst_b     (rst_b),
        .clear     (accept),
        .bit_valid (crc_vld),
        .bit_in    (raw),
        .mode      (mode_q),
        .crc_out   (crc_out)
    );

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        lvl_d   = lvl_q;
        line_d  = line_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pid_d   = pid_q;
        pld_d   = pld_q;
        len_d   = len_q;
        mode_d  = mode_q;
        crc_vld = 1'b0;
        raw     = 1'b0;
        last    = 1'b0;

        unique case (st_q)
            ST_SYNC: begin
                raw  = (idx_q == IDX_W'(SYNC_BITS - 1));
                last = raw;
            end
            ST_PID: begin
                raw  = pid_byte[idx_q[2:0]];
                last = (idx_q == IDX_W'(7));
            end
            ST_PLD: begin
                raw  = pld_q[idx_q[PI_W-1:0]];
                last = (idx_q == IDX_W'(len_q) - IDX_W'(1));
            end
            ST_CRC: begin
                raw  = crc_out[crc_i];
                last = (idx_q[3:0] == crc_last);
            end
            ST_EOP:  last = (idx_q == IDX_W'(EOP_SE0 - 1));
            default: ;
        endcase

        unique case (st_q)
            ST_IDLE: begin
                line_d = LINE_J;
                lvl_d  = 1'b1;
                if (!rdy_q) begin
                    rdy_d = 1'b1;
                end else if (pkt_avail) begin
                    pid_d  = pid;
                    pld_d  = payload;
                    len_d  = (pld_bits > LEN_W'(MAX_PLD_BITS)) ? LEN_W'(MAX_PLD_BITS) : pld_bits;
                    mode_d = (crc_mode == CRC_ILL) ? CRC_NONE : crc_mode_t'(crc_mode);
                    err_d  = (crc_mode == CRC_ILL);
                    rdy_d  = 1'b0;
                    busy_d = 1'b1;
                    // First SYNC bit is a raw 0: the line toggles from J to K.
                    lvl_d  = 1'b0;
                    line_d = LINE_K;
                    ones_d = 3'd0;
                    st_d   = ST_SYNC;
                    idx_d  = IDX_W'(1);
                end
            end
            ST_SYNC, ST_PID, ST_PLD, ST_CRC, ST_EOP: begin
                if (ones_q == STUFF_RUN) begin
                    // Owed stuff bit goes out before the next field element, including EOP.
                    lvl_d  = ~lvl_q;
                    line_d = nrzi_line(~lvl_q);
                    ones_d = 3'd0;
                end else if (st_q == ST_EOP) begin
                    line_d = LINE_SE0;
                    if (last) begin
                        st_d  = ST_IDLE_J;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    ones_d  = raw ? ones_q + 3'd1 : 3'd0;
                    lvl_d   = raw ? lvl_q : ~lvl_q;
                    line_d  = nrzi_line(raw ? lvl_q : ~lvl_q);
                    crc_vld = (st_q == ST_PLD);
                    if (last) begin
                        idx_d = '0;
                        unique case (st_q)
                            ST_SYNC: st_d = ST_PID;
                            ST_PID:  st_d = nxt_pid;
                            ST_PLD:  st_d = nxt_pld;
                            default: st_d = ST_EOP;
                        endcase
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_IDLE_J: begin
                line_d = LINE_J;
                lvl_d  = 1'b1;
                done_d = 1'b1;
                busy_d = 1'b0;
                st_d   = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            st_q   <= ST_IDLE;
            idx_q  <= '0;
            ones_q <= 3'd0;
            lvl_q  <= 1'b1;
            line_q <= LINE_J;
            rdy_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            pid_q  <= 4'd0;
            pld_q  <= '0;
            len_q  <= '0;
            mode_q <= CRC_NONE;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            ones_q <= ones_d;
            lvl_q  <= lvl_d;
            line_q <= line_d;
            rdy_q  <= rdy_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
            pid_q  <= pid_d;
            pld_q  <= pld_d;
            len_q  <= len_d;
            mode_q <= mode_d;
        end
    end

    assign dp       = line_q[1];
    assign dm       = line_q[0];
    assign ready_in = rdy_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign cfg_err  = err_q;

`ifdef USB_TX_STUFF_CNT_EN
    logic [7:0] scnt_q, scnt_d;
    logic       stuff_now;

    assign stuff_now = (st_q inside {ST_SYNC, ST_PID, ST_PLD, ST_CRC, ST_EOP}) && (ones_q == STUFF_RUN);

    always_comb begin
        scnt_d = scnt_q;
        if (accept)
            scnt_d = 8'd0;
        else if (stuff_now && (scnt_q != 8'hFF))
            scnt_d = scnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_b)
            scnt_q <= 8'd0;
        else
            scnt_q <= scnt_d;
    end

    assign stuff_cnt = scnt_q;
`endif

endmodule
